// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - instruction fetch, stage sequencing and PC ownership for the CPU control path
module instruction_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_data,
    input  logic                mem_done,
    input  logic [31:0]         jump_cond_value,
    input  logic [31:0]         jump_addr_value,
    output logic [2:0]          stage,
    output logic [4:0]          current_instruction_type,
    output logic [4:0]          reg_a,
    output logic [4:0]          reg_b,
    output logic [4:0]          reg_c,
    output logic [31:0]         load_imm_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_FETCH_IMM  = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_REG_UPDATE = 3'd3,
        ST_PC_UPDATE  = 3'd4,
        ST_HALTED     = 3'd5
    } stage_t;

    localparam logic [4:0] T_NOP      = 5'd0;
    localparam logic [4:0] T_LOAD_IMM = 5'd1;
    localparam logic [4:0] T_LOAD     = 5'd2;
    localparam logic [4:0] T_STORE    = 5'd3;
    localparam logic [4:0] T_ALU_OP   = 5'd4;
    localparam logic [4:0] T_JUMP     = 5'd5;

    stage_t              state;
    stage_t              state_next;
    logic                accept;
    logic                fetching;
    logic                mem_op;
    logic                writes_reg;
    logic [PC_WIDTH-1:0] pc_next;

    assign stage    = state;
    assign fetching = (state == ST_FETCH) || (state == ST_FETCH_IMM);
    // imem_req is only ever high in a fetch stage, so this also filters stray valids
    assign accept   = imem_req && imem_valid && fetching;

    assign mem_op     = (current_instruction_type == T_LOAD) || (current_instruction_type == T_STORE);
    assign writes_reg = (current_instruction_type == T_LOAD_IMM) || (current_instruction_type == T_LOAD) ||
                        (current_instruction_type == T_ALU_OP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (accept) begin
                    if (imem_data[4:0] > T_JUMP) begin
                        state_next = ST_HALTED;
                    end else if (imem_data[4:0] == T_LOAD_IMM) begin
                        state_next = ST_FETCH_IMM;
                    end else begin
                        state_next = ST_EXECUTE;
                    end
                end
            end
            ST_FETCH_IMM: begin
                if (accept) begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (!mem_op || mem_done) begin
                    state_next = writes_reg ? ST_REG_UPDATE : ST_PC_UPDATE;
                end
            end
            ST_REG_UPDATE: state_next = ST_PC_UPDATE;
            ST_PC_UPDATE:  state_next = ST_FETCH;
            ST_HALTED:     state_next = ST_HALTED;
            default:       state_next = ST_HALTED;
        endcase
    end

    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        if (current_instruction_type == T_JUMP && jump_cond_value != 32'd0) begin
            pc_next = jump_addr_value[PC_WIDTH-1:0];
        end else if (current_instruction_type == T_LOAD_IMM) begin
            pc_next = pc + PC_WIDTH'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req                 <= 1'b0;
            imem_addr                <= '0;
            current_instruction_type <= T_NOP;
            reg_a                    <= '0;
            reg_b                    <= '0;
            reg_c                    <= '0;
            load_imm_data            <= '0;
            pc                       <= RESET_PC;
            halted                   <= 1'b0;
        end else begin
            // Request is raised one cycle after entering a fetch stage and held until accepted
            if (accept) begin
                imem_req <= 1'b0;
            end else if (fetching && !imem_req) begin
                imem_req  <= 1'b1;
                imem_addr <= (state == ST_FETCH) ? pc : pc + PC_WIDTH'(1);
            end
            if (accept && state == ST_FETCH) begin
                current_instruction_type <= imem_data[4:0];
                reg_a                    <= imem_data[9:5];
                reg_b                    <= imem_data[14:10];
                reg_c                    <= imem_data[19:15];
            end
            if (accept && state == ST_FETCH_IMM) begin
                load_imm_data <= imem_data;
            end
            if (state == ST_PC_UPDATE) begin
                pc <= pc_next;
            end
            if (state_next == ST_HALTED) begin
                halted <= 1'b1;
            end
        end
    end

endmodule
